reg_file_fwd: RTL
=================

Name: reg_file_fwd

Overview:
Parametrised successor to the fixed 4x16 register group in the datapath. It provides 2^ADDR_W registers of DATA_W bits, one write port and two registered read ports (rd and rs). It adds same-cycle write-to-read forwarding, an optional hard-wired zero register, a stall/hold input and a per-register busy scoreboard. The block sits between instruction decode (addresses, en_in) and the ALU stage (rd_q/rs_q, en_out), with writeback driving the write port.

Parameters:
DATA_W, 16, register and data width in bits
ADDR_W, 2, address width; NREG = 2**ADDR_W registers
ZERO_REG, 0, if 1 then register 0 always reads 0, ignores writes and is never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset, sampled on rising edge of clk
en_in  in  1  read request from decode
stall  in  1  hold all read-side outputs this cycle
rd  in  ADDR_W  read address A
rs  in  ADDR_W  read address B
we  in  1  write enable from writeback
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
mark_en  in  1  set busy bit of mark_addr (producer issued)
mark_addr  in  ADDR_W  register to mark busy
en_out  out  1  read data valid, registered
rd_q  out  DATA_W  registered data for rd
rs_q  out  DATA_W  registered data for rs
rd_busy  out  1  registered busy flag for rd
rs_busy  out  1  registered busy flag for rs

Behaviour:
- Reset (rst==0 at posedge): all NREG registers = 0, all busy bits = 0, en_out = 0, rd_q = rs_q = 0, rd_busy = rs_busy = 0. Reset dominates every other input, including stall, we and mark_en.
- writable(a) = !(ZERO_REG==1 && a==0).
- Write: at posedge, if we && writable(wa), then mem[wa] <= wd. The write is independent of en_in and stall.
- Forwarded read value: fwd(a) =
  - 0 if !writable(a);
  - else wd if we && wa==a;
  - else mem[a].
- Read, 1-cycle latency, with stall taking priority:
  - stall==1: en_out, rd_q, rs_q, rd_busy and rs_busy all hold their values.
  - stall==0 && en_in==1: en_out <= 1; rd_q <= fwd(rd); rs_q <= fwd(rs); the busy flags update as below.
  - stall==0 && en_in==0: en_out <= 0; rd_q, rs_q and the busy flags hold.
- Scoreboard, per register i with writable(i):
  - next busy[i] = (mark_en && mark_addr==i) | (busy[i] & ~(we && wa==i)).
  - A mark and a write to the same register in the same cycle leaves it busy (the new producer wins).
  - mark_en on a non-writable register is ignored.
- Busy forwarding: the sampled flag is bf(a) = writable(a) && busy[a] && !(we && wa==a).
  - A same-cycle write clears the flag, consistent with data forwarding.
  - A same-cycle mark is NOT visible; it shows on the next read.
  - rd_busy <= bf(rd) and rs_busy <= bf(rs) under the read rule above.
- rd==rs is legal; both outputs carry the same value.
- Address arithmetic is exact: no wrap or aliasing, since all ADDR_W-bit values are valid.

Test Plan:
- Reset then read: rst=0 for 2 cycles; then en_in=1, rd=1, rs=2 -> next cycle en_out=1, rd_q=0, rs_q=0, both busy flags 0.
- Write then read: we=1, wa=3, wd=16'hA5A5; next cycle en_in=1, rd=3, rs=0 -> rd_q=16'hA5A5, rs_q=0, en_out=1.
- Forwarding: mem[2]=16'h1111; in the same cycle we=1, wa=2, wd=16'h2222 and en_in=1, rd=2, rs=2 -> rd_q=rs_q=16'h2222; a read the following cycle also returns 16'h2222.
- Stall hold: rd_q=16'h00FF, en_out=1; assert stall=1 for 3 cycles while writing and toggling en_in -> all outputs unchanged; release with en_in=0 -> en_out=0, rd_q stays 16'h00FF.
- Scoreboard:
  - mark_en=1, mark_addr=1; next cycle read rd=1 -> rd_busy=1.
  - Then we=1, wa=1 with a read of rd=1 in the same cycle -> rd_busy=0.
  - Simultaneous mark and write to register 1 -> a later read gives rd_busy=1.
- ZERO_REG=1 instance: we=1, wa=0, wd=16'hFFFF plus mark_en on register 0; then read rd=0 -> rd_q=0, rd_busy=0. Assert rst=0 mid-stream with stall=1 -> all outputs 0 after that edge.

Source files
------------

// File: rtl/reg_file_fwd.sv
// Parametrised register file with two registered read ports, write-to-read
// forwarding, an optional hard-wired zero register, a stall hold and a busy scoreboard.
module reg_file_fwd #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic              stall,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              en_out,
    output logic [DATA_W-1:0] rd_q,
    output logic [DATA_W-1:0] rs_q,
    output logic              rd_busy,
    output logic              rs_busy
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   busy;

    logic [DATA_W-1:0] rd_fwd, rs_fwd;
    logic              rd_bf, rs_bf;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG == 1 && a == '0);
    endfunction

    // A same-cycle write both supplies the data and retires the busy flag;
    // a same-cycle mark only becomes visible on the following read.
    always_comb begin
        rd_fwd = '0;
        rs_fwd = '0;
        rd_bf  = 1'b0;
        rs_bf  = 1'b0;
        if (writable(rd)) begin
            rd_fwd = (we && wa == rd) ? wd : mem[rd];
            rd_bf  = busy[rd] && !(we && wa == rd);
        end
        if (writable(rs)) begin
            rs_fwd = (we && wa == rs) ? wd : mem[rs];
            rs_bf  = busy[rs] && !(we && wa == rs);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            busy    <= '0;
            en_out  <= 1'b0;
            rd_q    <= '0;
            rs_q    <= '0;
            rd_busy <= 1'b0;
            rs_busy <= 1'b0;
        end else begin
            if (we && writable(wa)) begin
                mem[wa] <= wd;
            end
            for (int unsigned i = 0; i < NREG; i++) begin
                if (writable(ADDR_W'(i))) begin
                    busy[i] <= (mark_en && mark_addr == ADDR_W'(i)) ||
                               (busy[i] && !(we && wa == ADDR_W'(i)));
                end else begin
                    busy[i] <= 1'b0;
                end
            end
            if (!stall) begin
                en_out <= en_in;
                if (en_in) begin
                    rd_q    <= rd_fwd;
                    rs_q    <= rs_fwd;
                    rd_busy <= rd_bf;
                    rs_busy <= rs_bf;
                end
            end
        end
    end

endmodule
